if_id_ex_pipe: RTL and testbench

- Consumer side of the load-use hazard handshake: owns the PC, the IF/ID pipeline register and the ID/EX control register.
- Acts on pc_write_en, ifid_write_en and stall_flush from the hazard detector: holds the PC and IF/ID, and injects a control bubble into ID/EX.
- Applies branch-redirect flushes.
- Keeps saturating stall and flush counters, plus a sticky handshake-consistency error flag for debug and verification.

---
 rtl/if_id_ex_pipe.sv | 138 +++++++++++++
 tb/tb_if_id_ex_pipe.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_ex_pipe.sv
// PC, IF/ID and ID/EX control registers, acting on the hazard handshake and on branch redirects.
// All outputs are registered with one cycle of latency; stall/flush inputs hold or bubble the stages, with no ready/credit path.
module if_id_ex_pipe #(
    parameter int                 ADDR_W    = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 CTRL_W    = 9,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pc_write_en,
    input  logic               ifid_write_en,
    input  logic               stall_flush,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic [INSTR_W-1:0] imem_instr,
    input  logic [CTRL_W-1:0]  id_ctrl,
    input  logic [4:0]         id_rs,
    input  logic [4:0]         id_rt,
    input  logic [4:0]         id_rd,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic [ADDR_W-1:0]  ifid_pc4,
    output logic               ifid_valid,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic [4:0]         ex_rs,
    output logic [4:0]         ex_rt,
    output logic [4:0]         ex_rd,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic               proto_err
);

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
    logic [ADDR_W-1:0]  ifid_pc4_q, ifid_pc4_d;
    logic               ifid_valid_q, ifid_valid_d;
    logic [CTRL_W-1:0]  ex_ctrl_q, ex_ctrl_d;
    logic [4:0]         ex_rs_q, ex_rs_d;
    logic [4:0]         ex_rt_q, ex_rt_d;
    logic [4:0]         ex_rd_q, ex_rd_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               proto_err_q, proto_err_d;
    logic [ADDR_W-1:0]  pc_plus4;

    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_valid_d = ifid_valid_q;
        ex_ctrl_d    = id_ctrl;
        ex_rs_d      = id_rs;
        ex_rt_d      = id_rt;
        ex_rd_d      = id_rd;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        proto_err_d  = proto_err_q;

        if (branch_taken) begin
            pc_d = branch_target;
        end else if (pc_write_en) begin
            pc_d = pc_plus4;
        end

        if (branch_taken) begin
            ifid_instr_d = NOP_INSTR;
            ifid_pc4_d   = '0;
            ifid_valid_d = 1'b0;
        end else if (ifid_write_en) begin
            ifid_instr_d = imem_instr;
            ifid_pc4_d   = pc_plus4;
            ifid_valid_d = 1'b1;
        end

        // Register fields still flow on bubbles; only the control bundle is squashed.
        if (stall_flush || branch_taken) begin
            ex_ctrl_d = '0;
        end

        if (stall_flush && !branch_taken && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end

        // A consistent hazard handshake has both enables equal and stall_flush their inverse.
        if (!branch_taken && ((pc_write_en != ifid_write_en) || (stall_flush == pc_write_en))) begin
            proto_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q         <= RESET_PC;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc4_q   <= '0;
            ifid_valid_q <= 1'b0;
            ex_ctrl_q    <= '0;
            ex_rs_q      <= '0;
            ex_rt_q      <= '0;
            ex_rd_q      <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            ex_ctrl_q    <= ex_ctrl_d;
            ex_rs_q      <= ex_rs_d;
            ex_rt_q      <= ex_rt_d;
            ex_rd_q      <= ex_rd_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            proto_err_q  <= proto_err_d;
        end
    end

    assign pc         = pc_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc4   = ifid_pc4_q;
    assign ifid_valid = ifid_valid_q;
    assign ex_ctrl    = ex_ctrl_q;
    assign ex_rs      = ex_rs_q;
    assign ex_rt      = ex_rt_q;
    assign ex_rd      = ex_rd_q;
    assign stall_cnt  = stall_cnt_q;
    assign flush_cnt  = flush_cnt_q;
    assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_if_id_ex_pipe.sv
// Directed bench for if_id_ex_pipe with RESET_PC=0x100 and 2-bit counters to reach saturation quickly.
module tb_if_id_ex_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write_en;
    logic        ifid_write_en;
    logic        stall_flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [8:0]  id_ctrl;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [8:0]  ex_ctrl;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [1:0]  stall_cnt;
    logic [1:0]  flush_cnt;
    logic        proto_err;

    int checks   = 0;
    int failures = 0;

    if_id_ex_pipe #(
        .ADDR_W   (32),
        .INSTR_W  (32),
        .CTRL_W   (9),
        .RESET_PC (32'h0000_0100),
        .NOP_INSTR(32'h0000_0000),
        .CNT_W    (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_write_en  (pc_write_en),
        .ifid_write_en(ifid_write_en),
        .stall_flush  (stall_flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_instr   (imem_instr),
        .id_ctrl      (id_ctrl),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_rd        (id_rd),
        .pc           (pc),
        .ifid_instr   (ifid_instr),
        .ifid_pc4     (ifid_pc4),
        .ifid_valid   (ifid_valid),
        .ex_ctrl      (ex_ctrl),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_rd        (ex_rd),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .proto_err    (proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pwe, input logic iwe, input logic sf, input logic bt,
                         input logic [31:0] tgt);
        pc_write_en   = pwe;
        ifid_write_en = iwe;
        stall_flush   = sf;
        branch_taken  = bt;
        branch_target = tgt;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        imem_instr = 32'h8C22_0004;
        id_ctrl    = 9'h1A5;
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3;
        step();
        step();
        chk("rst_pc", pc, 32'h100);
        chk("rst_ifid_valid", ifid_valid, 0);
        chk("rst_ifid_instr", ifid_instr, 0);
        chk("rst_ifid_pc4", ifid_pc4, 0);
        chk("rst_ex_ctrl", ex_ctrl, 0);
        chk("rst_ex_rs", ex_rs, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_proto_err", proto_err, 0);

        reset = 1'b0;
        step();
        chk("run1_pc", pc, 32'h104);
        chk("run1_ifid_pc4", ifid_pc4, 32'h104);
        chk("run1_ifid_instr", ifid_instr, 32'h8C22_0004);
        chk("run1_ifid_valid", ifid_valid, 1);
        chk("run1_ex_ctrl", ex_ctrl, 9'h1A5);
        chk("run1_ex_rd", ex_rd, 3);
        step();
        chk("run2_pc", pc, 32'h108);
        chk("run2_ifid_pc4", ifid_pc4, 32'h108);

        // Load-use stall at pc=0x108
        imem_instr = 32'hDEAD_BEEF;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step();
        chk("stall_pc", pc, 32'h108);
        chk("stall_ifid_instr", ifid_instr, 32'h8C22_0004);
        chk("stall_ifid_pc4", ifid_pc4, 32'h108);
        chk("stall_ex_ctrl", ex_ctrl, 0);
        chk("stall_cnt1", stall_cnt, 1);
        chk("stall_proto", proto_err, 0);

        imem_instr = 32'h0043_0820;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("resume_pc", pc, 32'h10C);
        chk("resume_ifid_instr", ifid_instr, 32'h0043_0820);
        chk("resume_ifid_pc4", ifid_pc4, 32'h10C);
        chk("resume_ex_ctrl", ex_ctrl, 9'h1A5);
        chk("resume_stall_cnt", stall_cnt, 1);

        // Branch in the same cycle as a stall: branch wins
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h200);
        step();
        chk("br_pc", pc, 32'h200);
        chk("br_ifid_instr", ifid_instr, 0);
        chk("br_ifid_valid", ifid_valid, 0);
        chk("br_ifid_pc4", ifid_pc4, 0);
        chk("br_ex_ctrl", ex_ctrl, 0);
        chk("br_flush_cnt", flush_cnt, 1);
        chk("br_stall_cnt", stall_cnt, 1);
        chk("br_proto", proto_err, 0);

        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("post_br_pc", pc, 32'h204);
        chk("post_br_valid", ifid_valid, 1);
        chk("post_br_pc4", ifid_pc4, 32'h204);

        // Held stall: counter saturates at 3, register fields still pass
        drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        id_rs = 5'd7;
        step();
        chk("sat_cnt_a", stall_cnt, 2);
        chk("bubble_ex_rs", ex_rs, 7);
        chk("bubble_ex_ctrl", ex_ctrl, 0);
        for (int i = 0; i < 4; i++) step();
        chk("sat_cnt_b", stall_cnt, 3);
        chk("sat_pc_held", pc, 32'h204);

        // Inconsistent handshake: pc advances, IF/ID holds, error sticks
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        chk("perr_set", proto_err, 1);
        chk("perr_pc", pc, 32'h208);
        chk("perr_ifid_pc4", ifid_pc4, 32'h204);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("perr_sticky", proto_err, 1);
        chk("perr_next_pc", pc, 32'h20C);

        // PC wrap and flush counter saturation
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step();
        chk("wrap_tgt", pc, 32'hFFFF_FFFC);
        chk("flush_cnt2", flush_cnt, 2);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_pc4", ifid_pc4, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h300);
        step();
        chk("flush_cnt3", flush_cnt, 3);
        step();
        chk("flush_sat", flush_cnt, 3);
        chk("flush_pc", pc, 32'h300);

        // Mid-run reset overrides active inputs
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b1, 32'h400);
        step();
        chk("mrst_pc", pc, 32'h100);
        chk("mrst_valid", ifid_valid, 0);
        chk("mrst_ex_ctrl", ex_ctrl, 0);
        chk("mrst_ex_rs", ex_rs, 0);
        chk("mrst_stall", stall_cnt, 0);
        chk("mrst_flush", flush_cnt, 0);
        chk("mrst_proto", proto_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
